// File: rtl/servo_frame_sched.sv
// Frame scheduler for the two-channel (left/right) servo PWM path.
// Owns the shared tick prescaler and frame counter, accepts position updates
// over valid/ready, and applies them slew-limited only at frame boundaries.
module servo_frame_sched #(
  parameter int CLK_DIV      = 100,
  parameter int PERIOD_TICKS = 3000,
  parameter int MIN_PULSE    = 1000,
  parameter int POS_MAX      = 1000,
  parameter int POS_RESET    = 500,
  parameter int SLEW_STEP    = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        pos_valid,
  output logic        pos_ready,
  input  logic        pos_ch,
  input  logic [10:0] pos_val,
  output logic        pwm_left,
  output logic        pwm_right,
  output logic        frame_start,
  output logic        at_target,
  output logic        err_range
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic signed [12:0] SLEW_S = 13'(SLEW_STEP);

  typedef enum logic [1:0] {IDLE, RUN, LATCH} state_t;

  state_t        state, state_next;
  logic [PW-1:0] presc;
  logic [11:0]   cnt;
  logic [10:0]   target_l, target_r;
  logic [11:0]   active_l, active_r;
  logic [11:0]   goal_l, goal_r;
  logic          pwm_l_q, pwm_r_q, fs_q, err_q;
  logic          tick, wrap, ready_raw, xfer;

  // Move one active width toward its goal by at most SLEW_STEP; 13-bit signed so
  // the difference never wraps.
  function automatic logic [11:0] slew(input logic [11:0] act, input logic [11:0] goal);
    logic signed [12:0] d, s;
    logic        [12:0] sum;
    d = $signed({1'b0, goal}) - $signed({1'b0, act});
    if (d > SLEW_S)       s = SLEW_S;
    else if (d < -SLEW_S) s = -SLEW_S;
    else                  s = d;
    sum = $unsigned($signed({1'b0, act}) + s);
    return sum[11:0];
  endfunction

  assign goal_l = 12'(MIN_PULSE) + {1'b0, target_l};
  assign goal_r = 12'(MIN_PULSE) + {1'b0, target_r};
  assign tick   = (presc == PW'(CLK_DIV - 1));
  assign wrap   = tick && (cnt == 12'(PERIOD_TICKS - 1));
  assign xfer   = pos_valid && ready_raw;

  // State register.
  // NOTE: every clocked block uses non-blocking (<=) so all registers update
  // from the same pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake-ready decode.
  // NOTE: defaults are assigned before the case so no path leaves a signal
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    ready_raw  = 1'b1;
    case (state)
      IDLE:    if (enable) state_next = RUN;
      RUN:     if (!enable) state_next = IDLE;
               else if (wrap) state_next = LATCH;
      LATCH: begin
        ready_raw  = 1'b0;
        state_next = enable ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Prescaler and frame counter; held at 0 whenever not running.
  always_ff @(posedge clk) begin
    if (rst || !enable || state == IDLE) begin
      presc <= '0;
      cnt   <= '0;
    end else if (tick) begin
      presc <= '0;
      cnt   <= wrap ? 12'd0 : cnt + 12'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Targets from the handshake (clamped) and slew-limited active widths at LATCH.
  // NOTE: targets and active widths are ordinary registers, not memories, so they
  // are reset explicitly to the centre position.
  always_ff @(posedge clk) begin
    if (rst) begin
      target_l <= 11'(POS_RESET);
      target_r <= 11'(POS_RESET);
      active_l <= 12'(MIN_PULSE + POS_RESET);
      active_r <= 12'(MIN_PULSE + POS_RESET);
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (xfer) begin
        err_q <= (pos_val > 11'(POS_MAX));
        if (pos_ch) target_r <= (pos_val > 11'(POS_MAX)) ? 11'(POS_MAX) : pos_val;
        else        target_l <= (pos_val > 11'(POS_MAX)) ? 11'(POS_MAX) : pos_val;
      end
      if (state == LATCH) begin
        active_l <= slew(active_l, goal_l);
        active_r <= slew(active_r, goal_r);
      end
    end
  end

  // Registered PWM comparators and frame_start pulse on entry to RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_l_q <= 1'b0;
      pwm_r_q <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      pwm_l_q <= enable && (state != IDLE) && (cnt < active_l);
      pwm_r_q <= enable && (state != IDLE) && (cnt < active_r);
      fs_q    <= (state_next == RUN) && (state != RUN);
    end
  end

  // Outputs are forced low while rst is asserted, including the first reset cycle.
  assign pos_ready   = !rst && ready_raw;
  assign pwm_left    = !rst && pwm_l_q;
  assign pwm_right   = !rst && pwm_r_q;
  assign frame_start = !rst && fs_q;
  assign err_range   = !rst && err_q;
  assign at_target   = !rst && (active_l == goal_l) && (active_r == goal_r);

endmodule

// File: tb/tb_servo_frame_sched.sv
// Directed bench for servo_frame_sched using scaled-down timing parameters.
module tb_servo_frame_sched;

  localparam int D    = 4;
  localparam int P    = 40;
  localparam int MINP = 10;
  localparam int PMAX = 20;
  localparam int PRST = 10;
  localparam int SLEW = 3;
  localparam int FR   = D * P;

  logic        clk, rst, enable, pos_valid, pos_ready, pos_ch;
  logic [10:0] pos_val;
  logic        pwm_left, pwm_right, frame_start, at_target, err_range;

  int n_cmp = 0;
  int n_err = 0;
  int m_l, m_r, m_rz, m_ridx, m_ec, m_eidx;

  servo_frame_sched #(
    .CLK_DIV(D), .PERIOD_TICKS(P), .MIN_PULSE(MINP),
    .POS_MAX(PMAX), .POS_RESET(PRST), .SLEW_STEP(SLEW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .pos_valid(pos_valid), .pos_ready(pos_ready), .pos_ch(pos_ch), .pos_val(pos_val),
    .pwm_left(pwm_left), .pwm_right(pwm_right), .frame_start(frame_start),
    .at_target(at_target), .err_range(err_range)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no end of run, required finish before 400000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_fs(input int budget, input string tag);
    int n = 0;
    while (frame_start !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(frame_start), 1);
  endtask

  // Count pwm high cycles over one frame window starting at the current
  // (frame_start) negedge, issuing up to two single-cycle writes on the way.
  task automatic measure(input int wa, input logic ca, input int va,
                         input int wb, input logic cb, input int vb);
    m_l = 0; m_r = 0; m_rz = 0; m_ridx = -1; m_ec = 0; m_eidx = -1;
    for (int i = 0; i < FR; i++) begin
      if (pwm_left  === 1'b1) m_l++;
      if (pwm_right === 1'b1) m_r++;
      if (pos_ready !== 1'b1) begin m_rz++; m_ridx = i; end
      if (err_range === 1'b1) begin m_ec++; m_eidx = i; end
      pos_valid = 1'b0;
      if (i == wa) begin pos_valid = 1'b1; pos_ch = ca; pos_val = 11'(va); end
      if (i == wb) begin pos_valid = 1'b1; pos_ch = cb; pos_val = 11'(vb); end
      @(negedge clk);
    end
  endtask

  // Linear sequence of directed steps.
  initial begin
    rst = 1'b1; enable = 1'b0; pos_valid = 1'b0; pos_ch = 1'b0; pos_val = '0;

    // Reset state and idle behaviour.
    @(negedge clk);
    check("rst_ready", 32'(pos_ready), 0);
    check("rst_pwm_l", 32'(pwm_left), 0);
    check("rst_fs", 32'(frame_start), 0);
    check("rst_at_target", 32'(at_target), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(pos_ready), 1);
    check("idle_at_target", 32'(at_target), 1);
    check("idle_pwm_r", 32'(pwm_right), 0);

    // 1. Free-running frames at centre position.
    enable = 1'b1;
    wait_fs(4, "fs_first");
    measure(-1, 0, 0, -1, 0, 0);
    check("f1_left", m_l, (MINP + PRST) * D);
    check("f1_right", m_r, (MINP + PRST) * D);
    wait_fs(4, "fs_second");
    measure(-1, 0, 0, -1, 0, 0);
    check("f2_left", m_l, 20 * D);
    check("f2_period", 32'(frame_start), 1);
    check("f2_at_target", 32'(at_target), 1);

    // 2. Left to max mid-frame: current frame unchanged, then +3 per frame.
    measure(40, 0, 20, -1, 0, 0);
    check("s2_cur_left", m_l, 20 * D);
    check("s2_err", m_ec, 0);
    check("s2_at_target0", 32'(at_target), 0);
    measure(-1, 0, 0, -1, 0, 0);
    check("s2_left_23", m_l, 23 * D);
    measure(-1, 0, 0, -1, 0, 0);
    check("s2_left_26", m_l, 26 * D);
    check("s2_at_target1", 32'(at_target), 0);
    measure(-1, 0, 0, -1, 0, 0);
    check("s2_left_29", m_l, 29 * D);
    check("s2_at_target2", 32'(at_target), 1);
    measure(-1, 0, 0, -1, 0, 0);
    check("s2_left_30", m_l, 30 * D);
    check("s2_right", m_r, 20 * D);

    // 3. Out-of-range right write clamps to POS_MAX and flags err_range once.
    measure(40, 1, 25, -1, 0, 0);
    check("s3_err_count", m_ec, 1);
    check("s3_err_cycle", m_eidx, 41);
    check("s3_cur_right", m_r, 20 * D);
    measure(-1, 0, 0, -1, 0, 0);
    check("s3_right_23", m_r, 23 * D);
    measure(-1, 0, 0, -1, 0, 0);
    measure(-1, 0, 0, -1, 0, 0);
    check("s3_right_29", m_r, 29 * D);
    measure(-1, 0, 0, -1, 0, 0);
    check("s3_right_30", m_r, 30 * D);
    check("s3_ready_zeros", m_rz, 1);
    check("s3_ready_latch", m_ridx, FR - 1);
    measure(-1, 0, 0, -1, 0, 0);
    check("s3_right_cap", m_r, 30 * D);

    // 4. Two left writes in one frame: latest (15) wins, not 5.
    measure(40, 0, 5, 60, 0, 15);
    check("s4_cur_left", m_l, 30 * D);
    measure(-1, 0, 0, -1, 0, 0);
    check("s4_left_27", m_l, 27 * D);
    measure(-1, 0, 0, -1, 0, 0);
    check("s4_left_25", m_l, 25 * D);
    check("s4_at_target", 32'(at_target), 1);
    // Held pos_valid across LATCH transfers in the following cycle.
    repeat (FR - 2) @(negedge clk);
    check("s4_ready_before", 32'(pos_ready), 1);
    @(negedge clk);
    check("s4_ready_latch", 32'(pos_ready), 0);
    pos_valid = 1'b1; pos_ch = 1'b0; pos_val = 11'd10;
    @(negedge clk);
    check("s4_fs_after_latch", 32'(frame_start), 1);
    check("s4_ready_after", 32'(pos_ready), 1);
    @(negedge clk);
    pos_valid = 1'b0;
    wait_fs(FR + 2, "s4_fs_next");
    measure(-1, 0, 0, -1, 0, 0);
    check("s4_left_22", m_l, 22 * D);
    measure(-1, 0, 0, -1, 0, 0);
    check("s4_left_20", m_l, 20 * D);

    // 5. Disable mid-pulse, update while idle, re-enable.
    repeat (27) @(negedge clk);
    check("s5_pwm_before", 32'(pwm_left), 1);
    enable = 1'b0;
    @(negedge clk);
    check("s5_pwm_l_off", 32'(pwm_left), 0);
    check("s5_pwm_r_off", 32'(pwm_right), 0);
    pos_valid = 1'b1; pos_ch = 1'b1; pos_val = 11'd0;
    @(negedge clk);
    pos_valid = 1'b0;
    check("s5_idle_ready", 32'(pos_ready), 1);
    repeat (3) @(negedge clk);
    check("s5_idle_fs", 32'(frame_start), 0);
    check("s5_idle_pwm", 32'(pwm_left), 0);
    enable = 1'b1;
    wait_fs(4, "s5_fs_resume");
    measure(-1, 0, 0, -1, 0, 0);
    check("s5_left_kept", m_l, 20 * D);
    check("s5_right_kept", m_r, 30 * D);
    wait_fs(4, "s5_fs_next");
    measure(-1, 0, 0, -1, 0, 0);
    check("s5_right_27", m_r, 27 * D);
    check("s5_at_target", 32'(at_target), 0);

    // 6. Reset mid-pulse.
    repeat (10) @(negedge clk);
    check("s6_pwm_before", 32'(pwm_left), 1);
    rst = 1'b1; enable = 1'b0;
    #1;
    check("s6_rst_pwm", 32'(pwm_left), 0);
    check("s6_rst_ready", 32'(pos_ready), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("s6_idle_ready", 32'(pos_ready), 1);
    check("s6_idle_at_target", 32'(at_target), 1);
    enable = 1'b1;
    wait_fs(4, "s6_fs");
    measure(-1, 0, 0, -1, 0, 0);
    check("s6_left", m_l, 20 * D);
    check("s6_right", m_r, 20 * D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
